// File: rtl/serial_cmd_initiator.sv
// UART command initiator: sends opcode (+ optional argument), collects a sized response as bytes and LE words.
// Byte/word outputs lag rxReady by one cycle; transmit stalls while txBusy is high, receive aborts after TIMEOUT_CYCLES idle.
module serial_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RESP       = 136
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd_byte,
  input  logic [7:0]  arg_byte,
  input  logic        has_arg,
  input  logic [7:0]  resp_len,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [7:0]  byte_index,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [5:0]  word_index,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  stray_count
);

  localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_RESP_B = 8'(MAX_RESP);

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_CMD_GAP,
    TX_ARG,
    TX_ARG_GAP,
    RECV,
    FINISH
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [7:0]      r_cmd;
  logic [7:0]      r_arg;
  logic            r_has_arg;
  logic [7:0]      r_resp_len;
  logic [7:0]      r_rx_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [31:0]     r_word_acc;
  logic            r_byte_valid;
  logic [7:0]      r_byte_data;
  logic [7:0]      r_byte_index;
  logic            r_word_valid;
  logic [31:0]     r_word_data;
  logic [5:0]      r_word_index;
  logic            r_timeout;
  logic [7:0]      r_stray;

  logic            w_accept;
  logic            w_tx_start;
  logic [7:0]      w_tx_data;
  logic            w_rx_take;
  logic            w_expire;
  logic            w_remaining_zero;
  logic            w_to_limit;

  assign w_remaining_zero = (r_rx_cnt == r_resp_len);
  assign w_to_limit       = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_tx_start = 1'b0;
    w_tx_data  = 8'd0;
    w_rx_take  = 1'b0;
    w_expire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = TX_CMD;
        end
      end
      TX_CMD: begin
        if (!txBusy) begin
          w_tx_start = 1'b1;
          w_tx_data  = r_cmd;
          w_next     = TX_CMD_GAP;
        end
      end
      // One blind cycle lets the UART raise txBusy before we look at it again.
      TX_CMD_GAP: w_next = r_has_arg ? TX_ARG : RECV;
      TX_ARG: begin
        if (!txBusy) begin
          w_tx_start = 1'b1;
          w_tx_data  = r_arg;
          w_next     = TX_ARG_GAP;
        end
      end
      TX_ARG_GAP: w_next = RECV;
      RECV: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rxReady && !w_remaining_zero) begin
          w_rx_take = 1'b1;
          if (r_rx_cnt == r_resp_len - 8'd1) begin
            w_next = FINISH;
          end
        end else if (w_remaining_zero && !txBusy) begin
          w_next = FINISH;
        end else if (w_to_limit) begin
          w_expire = 1'b1;
          w_next   = IDLE;
        end
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd        <= 8'd0;
      r_arg        <= 8'd0;
      r_has_arg    <= 1'b0;
      r_resp_len   <= 8'd0;
      r_rx_cnt     <= 8'd0;
      r_to_cnt     <= '0;
      r_word_acc   <= 32'd0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_byte_index <= 8'd0;
      r_word_valid <= 1'b0;
      r_word_data  <= 32'd0;
      r_word_index <= 6'd0;
      r_timeout    <= 1'b0;
      r_stray      <= 8'd0;
    end else begin
      r_byte_valid <= 1'b0;
      r_word_valid <= 1'b0;
      r_timeout    <= w_expire;

      if (w_accept) begin
        r_cmd      <= cmd_byte;
        r_arg      <= arg_byte;
        r_has_arg  <= has_arg;
        r_resp_len <= (resp_len > MAX_RESP_B) ? MAX_RESP_B : resp_len;
        r_rx_cnt   <= 8'd0;
        r_word_acc <= 32'd0;
      end

      if (r_state != RECV || w_rx_take) begin
        r_to_cnt <= '0;
      end else if (!w_to_limit) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      if (w_rx_take) begin
        r_byte_valid <= 1'b1;
        r_byte_data  <= rxData;
        r_byte_index <= r_rx_cnt;
        r_rx_cnt     <= r_rx_cnt + 8'd1;
        r_word_acc[{r_rx_cnt[1:0], 3'b000} +: 8] <= rxData;
        if (r_rx_cnt[1:0] == 2'd3) begin
          r_word_valid <= 1'b1;
          r_word_data  <= {rxData, r_word_acc[23:0]};
          r_word_index <= r_rx_cnt[7:2];
        end
      end

      if (w_expire) begin
        r_word_acc <= 32'd0;
      end

      if (rxReady && r_state != RECV && r_stray != 8'hFF) begin
        r_stray <= r_stray + 8'd1;
      end
    end
  end

  assign txStart     = w_tx_start;
  assign txData      = w_tx_data;
  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign byte_index  = r_byte_index;
  assign word_valid  = r_word_valid;
  assign word_data   = r_word_data;
  assign word_index  = r_word_index;
  // Held through the timeout pulse cycle even though the FSM is already back in IDLE.
  assign busy        = (r_state != IDLE) || r_timeout;
  assign done        = (r_state == FINISH);
  assign timeout     = r_timeout;
  assign stray_count = r_stray;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Randomised scoreboard bench for serial_cmd_initiator with a small UART busy model.
module tb_serial_cmd_initiator;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd_byte = 8'd0;
  logic [7:0]  arg_byte = 8'd0;
  logic        has_arg = 1'b0;
  logic [7:0]  resp_len = 8'd0;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData = 8'd0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [7:0]  byte_index;
  logic        word_valid;
  logic [31:0] word_data;
  logic [5:0]  word_index;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  stray_count;

  serial_cmd_initiator #(.TIMEOUT_CYCLES(TO), .MAX_RESP(136)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_byte(cmd_byte), .arg_byte(arg_byte),
    .has_arg(has_arg), .resp_len(resp_len), .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_index(byte_index), .word_valid(word_valid), .word_data(word_data),
    .word_index(word_index), .busy(busy), .done(done), .timeout(timeout), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  q_tx[$];
  logic [15:0] q_byte[$];
  logic [37:0] q_word[$];
  int          q_evt[$];   // 1 done, 2 timeout, 3 done with txBusy required low
  int tx_seen = 0, evt_seen = 0, word_seen = 0;
  int last_bv_cyc = 0, to_cyc = 0, done_cyc = 0, last_tx_cyc = 0;
  logic prev_tx = 1'b0;
  int busy_len = 0;
  logic [7:0] dbuf[256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (reset) begin
      prev_tx = 1'b0;
    end else begin
      if (txStart) begin
        chk("tx_while_busy", {31'd0, txBusy}, 0);
        chk("tx_back_to_back", {31'd0, prev_tx}, 0);
        if (q_tx.size() == 0) chk("tx_unexpected", {24'd0, txData} | 32'h100, 0);
        else chk("tx_data", {24'd0, txData}, {24'd0, q_tx.pop_front()});
        tx_seen++;
        last_tx_cyc = cyc;
      end
      prev_tx = txStart;
      if (byte_valid) begin
        logic [15:0] e;
        if (q_byte.size() == 0) chk("byte_unexpected", {31'd0, byte_valid}, 0);
        else begin
          e = q_byte.pop_front();
          chk("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
          chk("byte_index", {24'd0, byte_index}, {24'd0, e[15:8]});
        end
        last_bv_cyc = cyc;
      end
      if (word_valid) begin
        logic [37:0] e;
        if (q_word.size() == 0) chk("word_unexpected", {31'd0, word_valid}, 0);
        else begin
          e = q_word.pop_front();
          chk("word_data", word_data, e[31:0]);
          chk("word_index", {26'd0, word_index}, {26'd0, e[37:32]});
        end
        word_seen++;
      end
      if (done || timeout) begin
        int e;
        chk("busy_at_end", {31'd0, busy}, 1);
        if (q_evt.size() == 0) chk("evt_unexpected", {30'd0, done, timeout}, 0);
        else begin
          e = q_evt.pop_front();
          chk("done", {31'd0, done}, (e != 2) ? 1 : 0);
          chk("timeout", {31'd0, timeout}, (e == 2) ? 1 : 0);
          if (e == 3) chk("done_txidle", {31'd0, txBusy}, 0);
        end
        if (timeout) to_cyc = cyc;
        if (done) done_cyc = cyc;
        evt_seen++;
      end
    end
  end

  // UART model: raises txBusy the cycle after a launch, for busy_len cycles.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart && busy_len > 0) begin
        @(posedge clk);
        #1 txBusy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 txBusy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] c, input logic [7:0] a, input logic ha, input logic [7:0] len);
    start = 1'b1; cmd_byte = c; arg_byte = a; has_arg = ha; resp_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rxReady = 1'b1; rxData = d;
    step();
    rxReady = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 3000 && tx_seen < target; i++) step();
    chk("tx_count_reached", (tx_seen >= target) ? 1 : 0, 1);
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic ha, input logic [7:0] len,
                         input int nsend, input int blen, input bit poke);
    int clampl = (len > 136) ? 136 : int'(len);
    int ns = (nsend < clampl) ? nsend : clampl;
    int tx0 = tx_seen;
    int ev0 = evt_seen;
    busy_len = blen;
    q_tx.push_back(c);
    if (ha) q_tx.push_back(a);
    for (int k = 0; k < ns; k++) begin
      q_byte.push_back({8'(k), dbuf[k]});
      if (k % 4 == 3) q_word.push_back({6'(k / 4), dbuf[k], dbuf[k-1], dbuf[k-2], dbuf[k-3]});
    end
    q_evt.push_back((ns == clampl) ? ((clampl == 0) ? 3 : 1) : 2);
    pulse_start(c, a, ha, len);
    wait_tx(tx0 + (ha ? 2 : 1));
    repeat (3) step();
    for (int k = 0; k < ns; k++) begin
      send_byte(dbuf[k]);
      if (poke && k == 0) begin
        start = 1'b1; cmd_byte = 8'hEE; has_arg = 1'b1;
        step();
        start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
    end
    for (int i = 0; i < 3 * TO + 500 && evt_seen < ev0 + 1; i++) step();
    chk("evt_arrived", evt_seen, ev0 + 1);
    @(negedge clk);
    chk("busy_after_end", {31'd0, busy}, 0);
    step();
  endtask

  initial begin
    int w0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_stray", {24'd0, stray_count}, 0);
    chk("rst_outs", {28'd0, txStart, byte_valid, word_valid, done | timeout}, 0);
    step();
    reset = 1'b0;
    step();

    // Single-byte response, no word.
    dbuf[0] = 8'h17;
    w0 = word_seen;
    run_cmd(8'h00, 8'h00, 1'b0, 8'd1, 255, 0, 1'b0);
    chk("single_no_word", word_seen - w0, 0);

    // Opcode + argument against a slow transmitter, empty response.
    run_cmd(8'h01, 8'h0A, 1'b1, 8'd0, 0, 20, 1'b0);
    chk("done_after_txbusy", (done_cyc - last_tx_cyc > 20) ? 1 : 0, 1);

    // Maximum length, value == index.
    for (int k = 0; k < 136; k++) dbuf[k] = 8'(k);
    w0 = word_seen;
    run_cmd(8'h0A, 8'h00, 1'b0, 8'd136, 255, 2, 1'b0);
    chk("max_word_count", word_seen - w0, 34);

    // Partial response then silence.
    for (int k = 0; k < 6; k++) dbuf[k] = 8'($urandom);
    w0 = word_seen;
    run_cmd(8'h22, 8'h00, 1'b0, 8'd6, 3, 0, 1'b0);
    chk("timeout_latency", to_cyc - last_bv_cyc, TO);
    chk("timeout_no_word", word_seen - w0, 0);

    // Strays in IDLE saturate.
    for (int i = 0; i < 100; i++) send_byte(8'($urandom));
    @(negedge clk);
    chk("stray_100", {24'd0, stray_count}, 100);
    step();
    for (int i = 0; i < 200; i++) send_byte(8'($urandom));
    @(negedge clk);
    chk("stray_sat", {24'd0, stray_count}, 255);
    step();

    // A start while receiving must be ignored.
    for (int k = 0; k < 8; k++) dbuf[k] = 8'($urandom);
    run_cmd(8'h44, 8'h00, 1'b0, 8'd8, 255, 1, 1'b1);

    // Reset in the middle of a response.
    busy_len = 0;
    q_tx.push_back(8'h33);
    q_byte.push_back({8'd0, 8'hA5});
    q_byte.push_back({8'd1, 8'h5A});
    pulse_start(8'h33, 8'h00, 1'b0, 8'd8);
    wait_tx(tx_seen + 1);
    repeat (3) step();
    send_byte(8'hA5);
    send_byte(8'h5A);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_ctrl", {26'd0, txStart, byte_valid, word_valid, busy, done, timeout}, 0);
    chk("mid_rst_data", {8'd0, txData, byte_data, byte_index}, 0);
    chk("mid_rst_word", word_data, 0);
    chk("mid_rst_widx_stray", {18'd0, word_index, stray_count}, 0);
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 5; k++) dbuf[k] = 8'($urandom);
    run_cmd(8'h55, 8'h00, 1'b0, 8'd5, 255, 0, 1'b0);

    // Random commands, including over-length and truncated responses.
    for (int n = 0; n < 14; n++) begin
      logic [7:0] len;
      int ns;
      len = 8'($urandom_range(0, 140));
      ns = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : 255;
      for (int k = 0; k < 256; k++) dbuf[k] = 8'($urandom);
      run_cmd(8'($urandom), 8'($urandom), 1'($urandom), len, ns, $urandom_range(0, 4), 1'b0);
    end

    chk("queues_drained", q_tx.size() + q_byte.size() + q_word.size() + q_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cmd_initiator.md
SERIAL_CMD_INITIATOR -- requirements
Module: serial_cmd_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000, clk cycles allowed between response bytes before abort.
REQ-002 Parameter MAX_RESP, default 136, largest legal response length in bytes.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to issue a command.
REQ-006 cmd_byte  input  8  command opcode, sampled on start.
REQ-007 arg_byte  input  8  argument byte, sampled on start.
REQ-008 has_arg  input  1  1 = send arg_byte after cmd_byte, sampled on start.
REQ-009 resp_len  input  8  expected response bytes (0..MAX_RESP), sampled on start.
REQ-010 txBusy  input  1  UART transmitter busy.
REQ-011 txStart  output  1  one-cycle pulse launching txData.
REQ-012 txData  output  8  byte to transmit.
REQ-013 rxReady  input  1  one-cycle strobe, rxData valid.
REQ-014 rxData  input  8  received byte.
REQ-015 byte_valid  output  1  pulse per accepted response byte.
REQ-016 byte_data  output  8  accepted response byte.
REQ-017 byte_index  output  8  0-based position of byte_data in the response.
REQ-018 word_valid  output  1  pulse per completed 32-bit word.
REQ-019 word_data  output  32  little-endian assembled word.
REQ-020 word_index  output  6  0-based word number.
REQ-021 busy  output  1  high from accepted start until done/timeout pulse cycle inclusive.
REQ-022 done  output  1  one-cycle pulse, command completed normally.
REQ-023 timeout  output  1  one-cycle pulse, response aborted by timeout.
REQ-024 stray_count  output  8  saturating count of rxReady strobes received while not in RECV.

Function
REQ-025 States SHALL be IDLE, TX_CMD, TX_CMD_GAP, TX_ARG, TX_ARG_GAP, RECV, FINISH.
REQ-026 IDLE: start latches cmd_byte, arg_byte, has_arg, resp_len (clamped to MAX_RESP), sets busy, goes TX_CMD next cycle; start outside IDLE ignored.
REQ-027 TX_CMD/TX_ARG: when txBusy low, drive txData and pulse txStart for exactly one cycle, enter matching GAP state; while txBusy high, wait.
REQ-028 GAP states ignore txBusy for exactly one cycle, then: TX_CMD_GAP -> TX_ARG if has_arg else RECV; TX_ARG_GAP -> RECV.
REQ-029 RECV with remaining count 0 SHALL wait for txBusy low, then enter FINISH.
REQ-030 RECV: each rxReady SHALL emit byte_valid the same cycle+1 with byte_data=rxData, byte_index=bytes received so far, and reload the timeout counter.
REQ-031 Word assembly: byte k lands in word_data bits [8*(k mod 4)+7 : 8*(k mod 4)]; word_valid pulses with the 4th byte's byte_valid; word_index = k div 4.
REQ-032 Trailing 1-3 bytes when resp_len not a multiple of 4 SHALL be emitted on byte_valid only, no word_valid.
REQ-033 After byte index resp_len-1 is emitted, enter FINISH; FINISH pulses done for one cycle, clears busy next cycle, returns IDLE.
REQ-034 Timeout counter counts clk cycles in RECV with no rxReady; at TIMEOUT_CYCLES it pulses timeout (not done), returns IDLE, discards partial word.
REQ-035 rxReady in any state other than RECV increments stray_count, saturating at 255, never emitted on byte_valid; cleared only by reset.
REQ-036 rxReady coincident with timeout expiry SHALL be accepted as a byte and the counter reloaded (byte wins).
REQ-037 txStart SHALL never be asserted on two consecutive cycles, nor while txBusy is high.

Reset
REQ-038 reset SHALL force IDLE and zero txStart, txData, byte_valid, byte_data, byte_index, word_valid, word_data, word_index, busy, done, timeout, stray_count, timeout counter, within one cycle, including mid-transmission or mid-reception; in-flight command abandoned.

Verification
REQ-039 start cmd=0x00, has_arg=0, resp_len=1; responder returns 0x17 -> one txStart with txData=0x00, byte_valid byte_data=0x17 index 0, no word_valid, done pulse.
REQ-040 start cmd=0x01, arg=0x0A, has_arg=1, resp_len=0, txBusy high 20 cycles after each txStart -> txStart with 0x01 then 0x0A, second only after txBusy low, done after txBusy falls.
REQ-041 start cmd=0x0A, resp_len=136, bytes 0..135 with value=index -> 34 word_valid, word 0 = 0x03020100, word 33 = 0x87868584, done once.
REQ-042 resp_len=6, send 3 bytes then silence, TIMEOUT_CYCLES=100 -> timeout pulse 100 cycles after third byte, no done, no word_valid, busy low after.
REQ-043 300 rxReady strobes in IDLE -> stray_count=255, no byte_valid; start during RECV ignored.
REQ-044 reset asserted while in RECV after 2 bytes -> all outputs zero next cycle; fresh command afterwards completes with byte_index starting at 0.
